// File: rtl/icfill_pkg.sv
// Shared types and constants for the I-cache line-fill responder.
// Line geometry defaults come from the global ICACHE_* defines; fallback
// values below apply only when the including build has not set them.
`ifndef ICACHE_TAG_BITS
`define ICACHE_TAG_BITS 20
`endif
`ifndef ICACHE_INDEX_BITS
`define ICACHE_INDEX_BITS 6
`endif
`ifndef ICACHE_BITS_IN_LINE
`define ICACHE_BITS_IN_LINE 256
`endif

package icfill_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        COLLECT,
        RESP
    } icfill_state_t;

    localparam int unsigned ICFILL_WORD_BITS  = 64;
    localparam int unsigned ICFILL_BEAT_CNT_W = $clog2(`ICACHE_BITS_IN_LINE / ICFILL_WORD_BITS);

endpackage

// File: rtl/icfill_line_assembler.sv
// Collects backing-memory beats into one cache line: beat k lands in
// bits [k*WORD_BITS +: WORD_BITS]. line_next exposes the line including
// the beat being written this cycle so the caller can capture a complete
// line on the same edge as the final beat.
module icfill_line_assembler
    import icfill_pkg::*;
#(
    parameter int unsigned WORD_BITS = ICFILL_WORD_BITS,
    parameter int unsigned BEATS     = 2 ** ICFILL_BEAT_CNT_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       enable,
    input  logic                       beat_valid,
    input  logic [WORD_BITS-1:0]       beat_data,
    output logic [WORD_BITS*BEATS-1:0] line_next,
    output logic                       done
);

    localparam int unsigned BEAT_W = $clog2(BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    logic [WORD_BITS*BEATS-1:0] line;
    logic [BEAT_W-1:0]          rx_cnt;
    logic                       done_q;
    logic                       take;
    logic                       last;

    assign take = enable && beat_valid;
    assign last = take && (rx_cnt == LAST_BEAT);
    assign done = done_q || last;

    // merge the incoming beat into the line image
    always_comb begin
        line_next = line;
        if (take) begin
            line_next[rx_cnt*WORD_BITS +: WORD_BITS] = beat_data;
        end
    end

    // line storage, wrapping beat counter and sticky done flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line   <= '0;
            rx_cnt <= '0;
            done_q <= 1'b0;
        end else if (clear) begin
            rx_cnt <= '0;
            done_q <= 1'b0;
        end else if (take) begin
            line   <= line_next;
            rx_cnt <= rx_cnt + 1'b1;
            if (last) begin
                done_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/icache_fill_responder.sv
// Memory-side responder for I-cache misses: accepts a block address, reads
// the line beat by beat from backing memory, and returns tag/index/data with
// a one-cycle valid pulse. Optional feature macro: ICFILL_PERF_CNT_EN adds
// saturating fill and grant-stall counters.
module icache_fill_responder
    import icfill_pkg::*;
#(
    parameter int unsigned TAG_BITS   = `ICACHE_TAG_BITS,
    parameter int unsigned INDEX_BITS = `ICACHE_INDEX_BITS,
    parameter int unsigned LINE_BITS  = `ICACHE_BITS_IN_LINE,
    parameter int unsigned WORD_BITS  = ICFILL_WORD_BITS,
    parameter int unsigned BEATS      = LINE_BITS / WORD_BITS
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [TAG_BITS+INDEX_BITS-1:0]            ic2memReqAddr_i,
    input  logic                                      ic2memReqValid_i,
    output logic [TAG_BITS-1:0]                       mem2icTag_o,
    output logic [INDEX_BITS-1:0]                     mem2icIndex_o,
    output logic [LINE_BITS-1:0]                      mem2icData_o,
    output logic                                      mem2icRespValid_o,
    output logic [TAG_BITS+INDEX_BITS+$clog2(BEATS)-1:0] memRdAddr_o,
    output logic                                      memRdReq_o,
    input  logic                                      memRdGnt_i,
    input  logic [WORD_BITS-1:0]                      memRdData_i,
    input  logic                                      memRdDataValid_i,
    output logic                                      busy_o
`ifdef ICFILL_PERF_CNT_EN
    ,
    output logic [31:0]                               fillCount_o,
    output logic [31:0]                               fillStallCycles_o
`endif
);

    localparam int unsigned ADDR_BITS = TAG_BITS + INDEX_BITS;
    localparam int unsigned BEAT_W    = $clog2(BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    icfill_state_t         state, state_next;
    logic [ADDR_BITS-1:0]  cur_addr, accept_addr, pend_addr;
    logic                  pend_valid, after_resp, accept, same_addr;
    logic [BEAT_W-1:0]     issue_cnt;
    logic                  last_gnt, collecting, line_done;
    logic [LINE_BITS-1:0]  line_next;

    assign same_addr  = (ic2memReqAddr_i == cur_addr);
    assign last_gnt   = (state == ISSUE) && memRdGnt_i && (issue_cnt == LAST_BEAT);
    assign collecting = (state == ISSUE) || (state == COLLECT);

    assign mem2icRespValid_o = (state == RESP);
    assign memRdReq_o        = (state == ISSUE);
    assign memRdAddr_o       = {cur_addr, issue_cnt};
    assign busy_o            = (state != IDLE);

    icfill_line_assembler #(
        .WORD_BITS (WORD_BITS),
        .BEATS     (BEATS)
    ) u_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (accept),
        .enable     (collecting),
        .beat_valid (memRdDataValid_i),
        .beat_data  (memRdData_i),
        .line_next  (line_next),
        .done       (line_done)
    );

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next state; in IDLE a pending request wins, and a repeat of the
    // just-served address in the cycle after RESP is a stale request
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        accept_addr = ic2memReqAddr_i;
        case (state)
            IDLE: begin
                if (pend_valid) begin
                    accept      = 1'b1;
                    accept_addr = pend_addr;
                end else if (ic2memReqValid_i && !(after_resp && same_addr)) begin
                    accept = 1'b1;
                end
                if (accept) begin
                    state_next = ISSUE;
                end
            end
            ISSUE:   if (last_gnt)  state_next = COLLECT;
            COLLECT: if (line_done) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // in-flight address, beat issue counter and one-entry pending request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_addr   <= '0;
            issue_cnt  <= '0;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            after_resp <= 1'b0;
        end else begin
            after_resp <= (state == RESP);
            if (accept) begin
                cur_addr  <= accept_addr;
                issue_cnt <= '0;
            end else if ((state == ISSUE) && memRdGnt_i) begin
                issue_cnt <= issue_cnt + 1'b1;
            end
            if (state == IDLE) begin
                if (accept && pend_valid) begin
                    pend_valid <= 1'b0;
                end
            end else if (ic2memReqValid_i && !same_addr) begin
                pend_valid <= 1'b1;
                pend_addr  <= ic2memReqAddr_i;
            end
        end
    end

    // response registers, loaded with the completed line on the final beat
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem2icTag_o   <= '0;
            mem2icIndex_o <= '0;
            mem2icData_o  <= '0;
        end else if ((state == COLLECT) && line_done) begin
            mem2icTag_o   <= cur_addr[ADDR_BITS-1 -: TAG_BITS];
            mem2icIndex_o <= cur_addr[INDEX_BITS-1:0];
            mem2icData_o  <= line_next;
        end
    end

`ifdef ICFILL_PERF_CNT_EN
    // saturating fill and grant-stall counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fillCount_o       <= '0;
            fillStallCycles_o <= '0;
        end else begin
            if ((state == RESP) && (fillCount_o != '1)) begin
                fillCount_o <= fillCount_o + 32'd1;
            end
            if ((state == ISSUE) && !memRdGnt_i && (fillStallCycles_o != '1)) begin
                fillStallCycles_o <= fillStallCycles_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_fill_responder.sv
// Self-checking bench for icache_fill_responder (LINE 256, WORD 64, 4 beats).
// A behavioural backing memory grants beats and returns data; expected
// responses are queued by the stimulus and checked by a separate monitor.
// ICFILL_PERF_CNT_EN, when defined, also enables the counter checks.
module tb_icache_fill_responder;

    localparam int unsigned TAG_BITS   = 20;
    localparam int unsigned INDEX_BITS = 6;
    localparam int unsigned LINE_BITS  = 256;
    localparam int unsigned WORD_BITS  = 64;
    localparam int unsigned ADDR_BITS  = TAG_BITS + INDEX_BITS;
    localparam int unsigned RA_BITS    = ADDR_BITS + 2;

    logic                  clk;
    logic                  reset;
    logic [ADDR_BITS-1:0]  req_addr;
    logic                  req_valid;
    logic [TAG_BITS-1:0]   resp_tag;
    logic [INDEX_BITS-1:0] resp_index;
    logic [LINE_BITS-1:0]  resp_data;
    logic                  resp_valid;
    logic [RA_BITS-1:0]    rd_addr;
    logic                  rd_req;
    logic                  rd_gnt;
    logic [WORD_BITS-1:0]  rd_data;
    logic                  rd_dv;
    logic                  busy;
`ifdef ICFILL_PERF_CNT_EN
    logic [31:0]           fill_count;
    logic [31:0]           stall_cycles;
`endif

    icache_fill_responder #(
        .TAG_BITS   (TAG_BITS),
        .INDEX_BITS (INDEX_BITS),
        .LINE_BITS  (LINE_BITS),
        .WORD_BITS  (WORD_BITS)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .ic2memReqAddr_i   (req_addr),
        .ic2memReqValid_i  (req_valid),
        .mem2icTag_o       (resp_tag),
        .mem2icIndex_o     (resp_index),
        .mem2icData_o      (resp_data),
        .mem2icRespValid_o (resp_valid),
        .memRdAddr_o       (rd_addr),
        .memRdReq_o        (rd_req),
        .memRdGnt_i        (rd_gnt),
        .memRdData_i       (rd_data),
        .memRdDataValid_i  (rd_dv),
        .busy_o            (busy)
`ifdef ICFILL_PERF_CNT_EN
        ,
        .fillCount_o       (fill_count),
        .fillStallCycles_o (stall_cycles)
`endif
    );

    typedef struct packed {
        logic [TAG_BITS-1:0]   tag;
        logic [INDEX_BITS-1:0] index;
        logic [LINE_BITS-1:0]  data;
    } resp_t;

    typedef struct packed {
        logic [31:0] due;
        logic [63:0] word;
    } beat_t;

    resp_t              exp_q[$];
    beat_t              data_q[$];
    logic [RA_BITS-1:0] gnt_log[$];

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;
    int unsigned resp_count    = 0;
    int unsigned last_resp_cyc = 0;
    int unsigned prev_resp_cyc = 0;

    int unsigned gnt_gap    = 0;
    int unsigned stall_beat = 99;
    int unsigned stall_len  = 0;
    int unsigned data_lat   = 0;
    logic [63:0] beat_base  = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [ADDR_BITS-1:0] a, input logic [LINE_BITS-1:0] d);
        resp_t e;
        e.tag   = a[ADDR_BITS-1 -: TAG_BITS];
        e.index = a[INDEX_BITS-1:0];
        e.data  = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_resp(input int unsigned target, input string name);
        int unsigned n = 0;
        while (resp_count < target && n < 200) begin
            tick();
            n++;
        end
        if (resp_count < target) begin
            total++;
            bad++;
            $display("FAIL %s: timeout, responses %0d want %0d", name, resp_count, target);
        end
    endtask

    // backing memory: grants after a configurable wait, returns beats in order
    initial begin : memory
        int unsigned wait_cnt;
        int unsigned need;
        logic        held;
        logic [RA_BITS-1:0] held_addr;
        beat_t       b;
        wait_cnt  = 0;
        held      = 1'b0;
        held_addr = '0;
        rd_gnt    = 1'b0;
        rd_dv     = 1'b0;
        rd_data   = '0;
        forever begin
            @(negedge clk);
            if (data_q.size() > 0 && data_q[0].due <= cyc) begin
                b       = data_q.pop_front();
                rd_dv   = 1'b1;
                rd_data = b.word;
            end else begin
                rd_dv   = 1'b0;
                rd_data = '0;
            end
            rd_gnt = 1'b0;
            if (rd_req) begin
                if (held) check("addr_hold", rd_addr, held_addr);
                need = (int'(rd_addr[1:0]) == stall_beat) ? stall_len : gnt_gap;
                if (wait_cnt >= need) begin
                    rd_gnt   = 1'b1;
                    wait_cnt = 0;
                    held     = 1'b0;
                    gnt_log.push_back(rd_addr);
                    b.due  = cyc + 1 + data_lat;
                    b.word = beat_base + 64'(rd_addr[1:0]);
                    data_q.push_back(b);
                end else begin
                    wait_cnt++;
                    held      = 1'b1;
                    held_addr = rd_addr;
                end
            end else begin
                wait_cnt = 0;
                held     = 1'b0;
            end
        end
    end

    // response monitor / scoreboard
    initial begin : monitor
        resp_t got;
        resp_t want;
        forever begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                prev_resp_cyc = last_resp_cyc;
                last_resp_cyc = cyc;
                resp_count++;
                got = '{resp_tag, resp_index, resp_data};
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL resp_unexpected: got tag %0h index %0h, want no response", resp_tag, resp_index);
                end else begin
                    want = exp_q.pop_front();
                    check("resp_tag", got.tag, want.tag);
                    check("resp_index", got.index, want.index);
                    check("resp_data", got.data, want.data);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int unsigned t0;
        int unsigned c0;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        repeat (3) tick();

        // reset state
        check("rst_tag", resp_tag, 0);
        check("rst_index", resp_index, 0);
        check("rst_data", resp_data, 0);
        check("rst_valid", resp_valid, 0);
        check("rst_req", rd_req, 0);
        check("rst_rdaddr", rd_addr, 0);
        check("rst_busy", busy, 0);
`ifdef ICFILL_PERF_CNT_EN
        check("rst_fill_count", fill_count, 0);
        check("rst_stall", stall_cycles, 0);
`endif
        reset = 1'b1;
        tick();

        // single fill of 0x123, grant and data every cycle
        beat_base = 64'hA;
        push_exp(26'h123, {64'hD, 64'hC, 64'hB, 64'hA});
        req_addr  = 26'h123;
        req_valid = 1'b1;
        t0 = cyc;
        tick();
        req_valid = 1'b0;
        wait_resp(1, "t1_resp");
        check("t1_latency", last_resp_cyc - t0, 6);
        check("t1_gnt_count", gnt_log.size(), 4);
        if (gnt_log.size() == 4) begin
            for (int i = 0; i < 4; i++) check("t1_rdaddr", gnt_log[i], 28'h48C + 28'(i));
        end
        gnt_log.delete();

        // grant withheld three cycles on beat 2
        beat_base  = 64'h20;
        stall_beat = 2;
        stall_len  = 3;
        push_exp(26'h077, {64'h23, 64'h22, 64'h21, 64'h20});
        req_addr  = 26'h077;
        req_valid = 1'b1;
        t0 = cyc;
        tick();
        req_valid = 1'b0;
        wait_resp(2, "t4_resp");
        stall_beat = 99;
        check("t4_latency", last_resp_cyc - t0, 9);
        check("t4_gnt_count", gnt_log.size(), 4);
        if (gnt_log.size() == 4) check("t4_rdaddr_beat2", gnt_log[2], 28'h1DE);
        gnt_log.delete();
        repeat (2) tick();
`ifdef ICFILL_PERF_CNT_EN
        check("t4_stall_cycles", stall_cycles, 3);
        check("t4_fill_count", fill_count, 2);
`endif

        // request held high for 10 cycles -> one fill
        beat_base = 64'h40;
        gnt_gap   = 2;
        push_exp(26'h123, {64'h43, 64'h42, 64'h41, 64'h40});
        c0 = resp_count;
        req_addr  = 26'h123;
        req_valid = 1'b1;
        repeat (10) tick();
        req_valid = 1'b0;
        wait_resp(c0 + 1, "t2_resp");
        gnt_gap = 0;
        repeat (8) tick();
        check("t2_one_fill", resp_count - c0, 1);
        check("t2_idle", busy, 0);

        // pending request: latest overwrites, served without bubble
        beat_base = 64'h100;
        push_exp(26'h010, {64'h103, 64'h102, 64'h101, 64'h100});
        push_exp(26'h030, {64'h103, 64'h102, 64'h101, 64'h100});
        c0 = resp_count;
        req_addr  = 26'h010;
        req_valid = 1'b1;
        tick();
        req_addr = 26'h020;
        tick();
        req_addr = 26'h030;
        tick();
        req_valid = 1'b0;
        wait_resp(c0 + 2, "t3_resp");
        check("t3_no_bubble", last_resp_cyc - prev_resp_cyc, 7);
        repeat (3) tick();

        // stale repeat after RESP dropped
        beat_base = 64'h60;
        push_exp(26'h123, {64'h63, 64'h62, 64'h61, 64'h60});
        c0 = resp_count;
        req_addr  = 26'h123;
        req_valid = 1'b1;
        wait_resp(c0 + 1, "t6_resp_a");
        tick();
        req_valid = 1'b0;
        check("t6_drop_same", busy, 0);
        repeat (3) tick();
        check("t6_no_extra", resp_count - c0, 1);

        // different address in the cycle after RESP accepted
        push_exp(26'h123, {64'h63, 64'h62, 64'h61, 64'h60});
        push_exp(26'h124, {64'h63, 64'h62, 64'h61, 64'h60});
        c0 = resp_count;
        req_addr  = 26'h123;
        req_valid = 1'b1;
        wait_resp(c0 + 1, "t6_resp_b");
        req_addr = 26'h124;
        tick();
        req_valid = 1'b0;
        check("t6_accept_other", busy, 1);
        wait_resp(c0 + 2, "t6_resp_c");
        repeat (3) tick();

        // reset while collecting beat 1
        data_lat  = 4;
        beat_base = 64'h50;
        req_addr  = 26'h055;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (6) tick();
        check("t5_in_collect", {busy, rd_req}, 2'b10);
        reset = 1'b0;
        #1;
        check("t5_rst_tag", resp_tag, 0);
        check("t5_rst_index", resp_index, 0);
        check("t5_rst_data", resp_data, 0);
        check("t5_rst_valid", resp_valid, 0);
        check("t5_rst_req", rd_req, 0);
        check("t5_rst_rdaddr", rd_addr, 0);
        check("t5_rst_busy", busy, 0);
`ifdef ICFILL_PERF_CNT_EN
        check("t5_rst_fill_count", fill_count, 0);
        check("t5_rst_stall", stall_cycles, 0);
`endif
        tick();
        reset    = 1'b1;
        data_lat = 0;
        repeat (4) tick();
        beat_base = 64'h80;
        push_exp(26'h056, {64'h83, 64'h82, 64'h81, 64'h80});
        c0 = resp_count;
        req_addr  = 26'h056;
        req_valid = 1'b1;
        t0 = cyc;
        tick();
        req_valid = 1'b0;
        wait_resp(c0 + 1, "t5_resp");
        check("t5_latency", last_resp_cyc - t0, 6);

        repeat (5) tick();
        check("exp_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
